// File: rtl/calc_shift_pkg.sv
// Shared encodings, FSM states and pipeline tag for the calc shift unit.
package calc_shift_pkg;

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned RESP_W = 2;
  localparam int unsigned PORT_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE = 4'b0000,
    CMD_SLL  = 4'b0101,
    CMD_SRL  = 4'b0110,
    CMD_SRA  = 4'b0111,
    CMD_ROL  = 4'b1000,
    CMD_ROR  = 4'b1001
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NONE    = 2'b00,
    RESP_OK      = 2'b01,
    RESP_INVALID = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OP2,
    ST_PEND
  } state_e;

  // Travels alongside the operand through both shifter stages
  typedef struct packed {
    logic              valid;
    logic [CMD_W-1:0]  cmd;
    logic [PORT_W-1:0] port;
  } pipe_tag_t;

  function automatic logic cmd_is_valid(input logic [CMD_W-1:0] cmd);
    logic ok;
    ok = 1'b0;
    case (cmd)
      CMD_SLL, CMD_SRL, CMD_SRA, CMD_ROL, CMD_ROR: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/calc_shift_pipe.sv
// Shared two-stage shifter: stage 1 applies the low amount bits, stage 2 the
// high bits and registers the result onto the originating port's outputs.
module calc_shift_pipe
  import calc_shift_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_PORTS = 4,
  localparam int unsigned SH_W     = $clog2(DATA_W)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  pipe_tag_t                             in_tag,
  input  logic [DATA_W-1:0]                     in_data,
  input  logic [SH_W-1:0]                       in_amt,
  output logic [NUM_PORTS-1:0][RESP_W-1:0]      out_resp,
  output logic [NUM_PORTS-1:0][0:DATA_W-1]      out_data
);

  localparam int unsigned LO_W = SH_W / 2;
  localparam int unsigned HI_W = SH_W - LO_W;

  pipe_tag_t         s1_tag;
  logic [DATA_W-1:0] s1_data;
  logic [HI_W-1:0]   s1_amt_hi;
  logic [DATA_W-1:0] s2_result;

  // Invalid commands shift to zero, so their data is already cleared
  function automatic logic [DATA_W-1:0] shift_by(input logic [CMD_W-1:0] cmd,
                                                 input logic [DATA_W-1:0] d,
                                                 input logic [SH_W-1:0]   amt);
    logic [2*DATA_W-1:0] dd;
    logic [DATA_W-1:0]   r;
    dd = {d, d};
    r  = '0;
    case (cmd)
      CMD_SLL: r = d << amt;
      CMD_SRL: r = d >> amt;
      CMD_SRA: r = DATA_W'($signed(d) >>> amt);
      CMD_ROL: begin
        dd = dd << amt;
        r  = dd[2*DATA_W-1 -: DATA_W];
      end
      CMD_ROR: begin
        dd = dd >> amt;
        r  = dd[DATA_W-1:0];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (in_tag.valid) begin
      s1_data   <= shift_by(in_tag.cmd, in_data, SH_W'(in_amt[LO_W-1:0]));
      s1_amt_hi <= in_amt[SH_W-1:LO_W];
    end
  end

  always_comb begin
    s2_result = shift_by(s1_tag.cmd, s1_data, {s1_amt_hi, {LO_W{1'b0}}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_tag   <= '0;
      out_resp <= '0;
      out_data <= '0;
    end else begin
      s1_tag <= in_tag;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        out_resp[p] <= RESP_NONE;
        out_data[p] <= '0;
        if (s1_tag.valid && s1_tag.port == PORT_W'(p)) begin
          if (cmd_is_valid(s1_tag.cmd)) begin
            out_resp[p] <= RESP_OK;
            out_data[p] <= s2_result;
          end else begin
            out_resp[p] <= RESP_INVALID;
          end
        end
      end
    end
  end

endmodule

// File: rtl/calc_shift_unit.sv
// Multi-port shift/rotate unit: per-port two-beat request FSMs, round-robin
// arbitration into one shared pipelined shifter.
module calc_shift_unit
  import calc_shift_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_PORTS = 4,
  localparam int unsigned SH_W     = $clog2(DATA_W)
) (
  input  logic                             c_clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0][CMD_W-1:0]  req_cmd_in,
  input  logic [NUM_PORTS-1:0][0:DATA_W-1] req_data_in,
  output logic [NUM_PORTS-1:0][RESP_W-1:0] out_resp,
  output logic [NUM_PORTS-1:0][0:DATA_W-1] out_data
);

  state_e            state   [NUM_PORTS];
  state_e            state_n [NUM_PORTS];
  logic [CMD_W-1:0]  cmd_q   [NUM_PORTS];
  logic [DATA_W-1:0] op1_q   [NUM_PORTS];
  logic [SH_W-1:0]   amt_q   [NUM_PORTS];
  logic [DATA_W-1:0] data_in [NUM_PORTS];

  logic [NUM_PORTS-1:0] pend;
  logic [NUM_PORTS-1:0] pend_rot;
  logic [NUM_PORTS-1:0] grant_vec;
  logic [PORT_W-1:0]    rr_ptr;
  logic [PORT_W-1:0]    grant_idx;
  logic                 grant_valid;
  int unsigned          sum;

  pipe_tag_t         issue_tag;
  logic [DATA_W-1:0] issue_data;
  logic [SH_W-1:0]   issue_amt;

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      data_in[p] = req_data_in[p];
      pend[p]    = (state[p] == ST_PEND);
    end
  end

  // Rotate the pending mask so the search starts at the pointer
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = 0;
    pend_rot    = NUM_PORTS'({pend, pend} >> rr_ptr);
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!grant_valid && pend_rot[i]) begin
        grant_valid = 1'b1;
        sum         = 32'(rr_ptr) + i;
        if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
        grant_idx   = PORT_W'(sum);
      end
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      grant_vec[p] = grant_valid && (grant_idx == PORT_W'(p));
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge c_clk) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      state[p] <= reset ? ST_IDLE : state_n[p];
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      state_n[p] = state[p];
      case (state[p])
        ST_IDLE: if (req_cmd_in[p] != '0) state_n[p] = ST_OP2;
        ST_OP2:  state_n[p] = ST_PEND;
        ST_PEND: if (grant_vec[p]) state_n[p] = ST_IDLE;
        default: state_n[p] = ST_IDLE;
      endcase
    end
  end

  // Only the amount bits of operand 2 are ever needed
  always_ff @(posedge c_clk) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (state[p] == ST_IDLE && req_cmd_in[p] != '0) begin
        cmd_q[p] <= req_cmd_in[p];
        op1_q[p] <= data_in[p];
      end
      if (state[p] == ST_OP2) begin
        amt_q[p] <= data_in[p][SH_W-1:0];
      end
    end
  end

  always_comb begin
    issue_tag       = '0;
    issue_data      = '0;
    issue_amt       = '0;
    issue_tag.valid = grant_valid;
    issue_tag.port  = grant_idx;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (grant_vec[p]) begin
        issue_tag.cmd = cmd_q[p];
        issue_data    = op1_q[p];
        issue_amt     = amt_q[p];
      end
    end
  end

  calc_shift_pipe #(
    .DATA_W   (DATA_W),
    .NUM_PORTS(NUM_PORTS)
  ) u_pipe (
    .clk     (c_clk),
    .reset   (reset),
    .in_tag  (issue_tag),
    .in_data (issue_data),
    .in_amt  (issue_amt),
    .out_resp(out_resp),
    .out_data(out_data)
  );

endmodule

// File: tb/tb_calc_shift_unit.sv
// Scoreboard bench for calc_shift_unit: drivers push expected responses,
// a negedge monitor pops and checks value and arrival cycle per port.
module tb_calc_shift_unit;

  localparam int NP = 4;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          lo;
    int          hi;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [NP-1:0][3:0]  cmd_in;
  logic [NP-1:0][31:0] data_in;
  logic [NP-1:0][1:0]  out_resp;
  logic [NP-1:0][31:0] out_data;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb [NP][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  calc_shift_unit #(.DATA_W(32), .NUM_PORTS(NP)) dut (
    .c_clk      (clk),
    .reset      (reset),
    .req_cmd_in (cmd_in),
    .req_data_in(data_in),
    .out_resp   (out_resp),
    .out_data   (out_data)
  );

  task automatic check(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s port%0d: got 0x%08h, required 0x%08h", name, p, act, exp);
    else n_pass++;
  endtask

  // Reference: shifts expressed as repeated single-bit moves
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [1:0] r, output logic [31:0] d);
    int n;
    n = int'(b % 32);
    r = 2'b01;
    d = a;
    case (c)
      4'd5: d = a << n;
      4'd6: d = a >> n;
      4'd7: repeat (n) d = {d[31], d[31:1]};
      4'd8: repeat (n) d = {d[30:0], d[31]};
      4'd9: repeat (n) d = {d[0], d[31:1]};
      default: begin r = 2'b10; d = '0; end
    endcase
  endfunction

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (reset) begin
        sb[p].delete();
        check("reset_resp", p, 32'(out_resp[p]), 32'd0);
        check("reset_data", p, out_data[p], 32'd0);
      end else if (out_resp[p] == 2'b00) begin
        check("idle_data", p, out_data[p], 32'd0);
      end else if (sb[p].size() == 0) begin
        n_total++;
        $display("FAIL unexpected_resp port%0d: got resp %0d at cycle %0d, required none", p, out_resp[p], cyc);
      end else begin
        exp_t e;
        e = sb[p].pop_front();
        check("resp", p, 32'(out_resp[p]), 32'(e.resp));
        check("data", p, out_data[p], e.data);
        n_total++;
        if (cyc < e.lo || cyc > e.hi)
          $display("FAIL latency port%0d: got cycle %0d, required %0d..%0d", p, cyc, e.lo, e.hi);
        else n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input int p, input logic [1:0] r, input logic [31:0] d, input int lo, input int hi);
    exp_t e;
    e.resp = r; e.data = d; e.lo = lo; e.hi = hi;
    sb[p].push_back(e);
  endtask

  task automatic wait_drain();
    int left;
    for (int i = 0; i < 80; i++) begin
      left = 0;
      for (int p = 0; p < NP; p++) left += sb[p].size();
      if (left == 0) break;
      step();
    end
    left = 0;
    for (int p = 0; p < NP; p++) left += sb[p].size();
    check("drain_pending", 0, 32'(left), 32'd0);
    repeat (4) step();
  endtask

  task automatic run_op(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] r, input logic [31:0] d);
    expect_resp(p, r, d, cyc + 4, cyc + 4);
    cmd_in[p] = c; data_in[p] = a;
    step();
    cmd_in[p] = 4'd0; data_in[p] = b;
    step();
    data_in[p] = '0;
    wait_drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  pc [NP];
    logic [31:0] pa [NP];
    int          pcyc [NP];
    bit          ph [NP];
    logic [1:0]  r;
    logic [31:0] d;
    logic [3:0]  c;

    reset = 1'b1; cmd_in = '0; data_in = '0;
    repeat (3) step();

    // All ports on the first edge after reset: consecutive responses 0..3
    reset = 1'b0;
    for (int p = 0; p < NP; p++) begin
      cmd_in[p] = 4'b0110; data_in[p] = 32'hFFFF_FFFF;
      expect_resp(p, 2'b01, 32'hFFFF_FFFF >> p, cyc + 4 + p, cyc + 4 + p);
    end
    step();
    cmd_in = '0;
    for (int p = 0; p < NP; p++) data_in[p] = 32'(p);
    step();
    data_in = '0;
    wait_drain();

    run_op(0, 4'b0101, 32'h0000_0001, 32'd31,        2'b01, 32'h8000_0000);
    run_op(1, 4'b0111, 32'h8000_0000, 32'h0000_0024, 2'b01, 32'hF800_0000);
    run_op(1, 4'b0110, 32'h8000_0000, 32'h0000_0024, 2'b01, 32'h0800_0000);
    run_op(2, 4'b1001, 32'h0000_0001, 32'd1,         2'b01, 32'h8000_0000);
    run_op(2, 4'b1000, 32'h8000_0001, 32'd4,         2'b01, 32'h0000_0018);
    run_op(0, 4'b0101, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 2'b01, 32'hDEAD_BEEF);

    // Invalid command, plus a second command while port 3 is pending
    expect_resp(3, 2'b10, 32'h0, cyc + 4, cyc + 4);
    cmd_in[3] = 4'b1111; data_in[3] = 32'h1234_5678;
    step();
    cmd_in[3] = 4'b0101; data_in[3] = 32'd3;
    step();
    cmd_in[3] = 4'b0101; data_in[3] = 32'd1;
    step();
    cmd_in[3] = 4'd0; data_in[3] = 32'd2;
    step();
    data_in[3] = '0;
    wait_drain();

    // New command presented while the previous response is showing
    expect_resp(0, 2'b01, 32'h0000_0010, cyc + 4, cyc + 4);
    cmd_in[0] = 4'b0101; data_in[0] = 32'h0000_0001;
    step();
    cmd_in[0] = 4'd0; data_in[0] = 32'd4;
    step();
    data_in[0] = '0;
    step(); step();
    expect_resp(0, 2'b01, 32'h0000_0001, cyc + 4, cyc + 4);
    cmd_in[0] = 4'b1001; data_in[0] = 32'h0000_0002;
    step();
    cmd_in[0] = 4'd0; data_in[0] = 32'd1;
    step();
    data_in[0] = '0;
    wait_drain();

    // Reset with two operations in flight, then a command right after
    for (int p = 0; p < 2; p++) begin
      cmd_in[p] = 4'b0101; data_in[p] = 32'h0000_0001;
      expect_resp(p, 2'b01, 32'h0000_0002, cyc + 4, cyc + 5);
    end
    step();
    cmd_in = '0; data_in[0] = 32'd1; data_in[1] = 32'd1;
    step();
    data_in = '0;
    step();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    expect_resp(2, 2'b01, 32'h8000_0000, cyc + 4, cyc + 4);
    cmd_in[2] = 4'b1001; data_in[2] = 32'h0000_0001;
    step();
    cmd_in[2] = 4'd0; data_in[2] = 32'd1;
    step();
    data_in = '0;
    wait_drain();

    // Randomised traffic on all ports against the reference model
    for (int p = 0; p < NP; p++) ph[p] = 1'b0;
    for (int t = 0; t < 500; t++) begin
      for (int p = 0; p < NP; p++) begin
        if (ph[p]) begin
          cmd_in[p] = 4'($urandom);
          data_in[p] = $urandom;
          model(pc[p], pa[p], data_in[p], r, d);
          expect_resp(p, r, d, pcyc[p] + 4, pcyc[p] + 4 + NP - 1);
          ph[p] = 1'b0;
        end else if (sb[p].size() == 0 && $urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 3) != 0) c = 4'($urandom_range(5, 9));
          else c = 4'($urandom_range(1, 15));
          cmd_in[p] = c; data_in[p] = $urandom;
          pc[p] = c; pa[p] = data_in[p]; pcyc[p] = cyc; ph[p] = 1'b1;
        end else begin
          cmd_in[p] = 4'd0; data_in[p] = $urandom;
        end
      end
      step();
    end
    cmd_in = '0;
    for (int p = 0; p < NP; p++) begin
      if (ph[p]) begin
        data_in[p] = $urandom;
        model(pc[p], pa[p], data_in[p], r, d);
        expect_resp(p, r, d, pcyc[p] + 4, pcyc[p] + 4 + NP - 1);
      end
    end
    step();
    data_in = '0;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
